lcd_timing_gen: RTL
===================

Name: lcd_timing_gen

Overview:
- Upstream source for the LVDS serializer wrapper.
- Generates panel raster timing (HSync, VSync, DataEnable) plus built-in test-pattern 6-bit RGB on the pixel clock. Outputs connect directly to the serializer's HSync/VSync/DataEnable/Red/Green/Blue inputs.
- Used for panel bring-up and as the default source when no frame source is attached.

Parameters:
- H_ACTIVE, 1024, active pixels per line (multiple of 8)
- H_FP, 24, horizontal front porch, pixels
- H_SYNC, 136, horizontal sync width, pixels
- H_BP, 160, horizontal back porch, pixels
- V_ACTIVE, 768, active lines per frame
- V_FP, 3, vertical front porch, lines
- V_SYNC, 6, vertical sync width, lines
- V_BP, 29, vertical back porch, lines
- HS_POL, 0, HSync asserted level (1 = active high)
- VS_POL, 0, VSync asserted level

Ports:
- pixel_clk  in  1  pixel clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- enable  in  1  run raster; low = hold idle
- pattern_sel  in  2  0 colour bars, 1 ramp, 2 checkerboard, 3 moving bar
- HSync  out  1  horizontal sync, level per HS_POL
- VSync  out  1  vertical sync, level per VS_POL
- DataEnable  out  1  high during active pixels
- Red  out  6  red component
- Green  out  6  green component
- Blue  out  6  blue component
- frame_start  out  1  one-cycle pulse coincident with first active pixel of a frame

Behaviour:
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (default 1344).
- V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (default 806).
- h_cnt counts 0..H_TOTAL-1 and wraps to 0. At wrap, v_cnt increments; v_cnt wraps 0..V_TOTAL-1.
- Line order: active [0,H_ACTIVE), front porch, sync [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC), back porch. Same order vertically on v_cnt.
- HSync depends on h_cnt only and toggles on every line, including vertical blanking.
- DataEnable = h active AND v active.
- All outputs are registered. Latency is exactly 1 cycle: outputs at edge n+1 reflect counters at edge n.
- Reset (rst=1, any time, including mid-frame): h_cnt=v_cnt=0, frame counter=0, latched pattern=0, bar position=0.
  - Output values: HSync=!HS_POL, VSync=!VS_POL, DataEnable=0, RGB=0, frame_start=0.
- enable=0: counters held at 0 and outputs forced to the reset values; the frame counter holds its value.
  - Raster restarts at (0,0) on the first cycle enable=1.
  - Dropping enable mid-frame aborts the frame immediately.
- pattern_sel is latched only when h_cnt=0 and v_cnt=0, so changes take effect at the next frame boundary, never mid-frame.
- RGB is 0 whenever DataEnable=0.
- Colour bars (pattern 0):
  - 8 bars, BAR_W = H_ACTIVE/8, in order white, yellow, cyan, green, magenta, red, blue, black (component 63 or 0).
  - Bar index comes from a pixel-in-bar counter plus a 3-bit index, reset at h_cnt=0. No divider.
- Ramp (pattern 1): R=G=B=h_cnt[5:0].
- Checkerboard (pattern 2): white (63) when h_cnt[5]^v_cnt[5]=0, else black.
- Moving bar (pattern 3):
  - Black background with a 16-px white vertical bar starting at x=bar_pos.
  - bar_pos advances by 4 at each frame start and wraps to 0 when bar_pos+4 >= H_ACTIVE.
  - The bar is clipped at the right edge, not wrapped.
- frame_start=1 on the output cycle where DataEnable is first asserted for (h=0, v=0); 0 otherwise.

Test Plan:
- rst high 3 cycles, then rst=0, enable=1, defaults:
  - DataEnable=1 on output edge 1 and stays high 1024 cycles; frame_start pulses once on that same edge.
  - HSync goes low (HS_POL=0) on output edge 1049 for 136 cycles.
- Full frame, pattern 0: per line, exactly 1024 DE-high cycles.
  - First 128 pixels RGB=(63,63,63); pixels 128..255 =(63,63,0); last 128 =(0,0,0).
  - VSync low for 6×1344 cycles starting at line 771, pixel 0 (+1 latency).
  - frame_start repeats every 1344×806 = 1083264 cycles.
- pattern_sel changed 0→2 mid-frame: the remainder of the frame stays colour bars.
  - Next frame pixel (32,0)=black, (0,32)=black, (32,32)=white.
- pattern 3 over 3 frames: bar occupies x=0..15, then 4..19, then 8..23.
  - Force bar_pos near the end: it wraps to 0 and the bar is clipped at x=1023.
- enable dropped at line 100: next edge all outputs idle (HSync=VSync=1, DE=0, RGB=0).
  - On re-enable, DE and frame_start reappear after 1 cycle.
- rst asserted mid-line during active video: next edge outputs at reset values.
  - After release, timing matches the first scenario exactly.

Source files
------------

// File: rtl/lcd_timing_gen.sv
// lcd_timing_gen
// Panel raster timing generator with built-in 6-bit RGB test patterns.
// Produces HSync/VSync/DataEnable and pixel data on the pixel clock, ready to
// feed the LVDS serializer wrapper directly. Every output is registered, and
// each output reflects the raster counters as they stood one edge earlier.

module lcd_timing_gen #(
    parameter int unsigned H_ACTIVE = 1024,  // active pixels per line, multiple of 8
    parameter int unsigned H_FP     = 24,
    parameter int unsigned H_SYNC   = 136,
    parameter int unsigned H_BP     = 160,
    parameter int unsigned V_ACTIVE = 768,
    parameter int unsigned V_FP     = 3,
    parameter int unsigned V_SYNC   = 6,
    parameter int unsigned V_BP     = 29,
    parameter bit          HS_POL   = 1'b0,  // asserted HSync level
    parameter bit          VS_POL   = 1'b0   // asserted VSync level
) (
    input  logic       pixel_clk,
    input  logic       rst,
    input  logic       enable,
    input  logic [1:0] pattern_sel,
    output logic       HSync,
    output logic       VSync,
    output logic       DataEnable,
    output logic [5:0] Red,
    output logic [5:0] Green,
    output logic [5:0] Blue,
    output logic       frame_start
);

    // ------------------------------------------------------------------
    // Derived geometry
    // ------------------------------------------------------------------
    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int unsigned HW      = $clog2(H_TOTAL);
    localparam int unsigned VW      = $clog2(V_TOTAL);
    localparam int unsigned XW      = HW + 1;  // headroom for bar arithmetic
    localparam int unsigned BAR_W   = H_ACTIVE / 8;
    localparam int unsigned BW      = (BAR_W > 1) ? $clog2(BAR_W) : 1;
    localparam int unsigned FW      = 16;

    localparam logic [HW-1:0] H_LAST      = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] H_ACT_END   = HW'(H_ACTIVE);
    localparam logic [HW-1:0] H_SYNC_BEG  = HW'(H_ACTIVE + H_FP);
    localparam logic [HW-1:0] H_SYNC_END  = HW'(H_ACTIVE + H_FP + H_SYNC);

    localparam logic [VW-1:0] V_LAST      = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] V_ACT_END   = VW'(V_ACTIVE);
    localparam logic [VW-1:0] V_SYNC_BEG  = VW'(V_ACTIVE + V_FP);
    localparam logic [VW-1:0] V_SYNC_END  = VW'(V_ACTIVE + V_FP + V_SYNC);

    localparam logic [BW-1:0] BAR_PX_LAST = BW'(BAR_W - 1);

    // Moving-bar geometry: 16 px wide, advancing 4 px per frame
    localparam logic [XW-1:0] MB_LEN      = XW'(16);
    localparam logic [XW-1:0] MB_STEP     = XW'(4);
    localparam logic [XW-1:0] MB_LIMIT    = XW'(H_ACTIVE);

    typedef enum logic [1:0] {
        PAT_BARS    = 2'd0,
        PAT_RAMP    = 2'd1,
        PAT_CHECKER = 2'd2,
        PAT_MOVING  = 2'd3
    } pattern_e;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [HW-1:0] h_cnt_q,     h_cnt_d;
    logic [VW-1:0] v_cnt_q,     v_cnt_d;
    logic [BW-1:0] bar_px_q,    bar_px_d;     // pixel within current colour bar
    logic [2:0]    bar_idx_q,   bar_idx_d;    // colour bar index for h_cnt_q
    pattern_e      pat_q,       pat_d;        // pattern in force for this frame
    logic [HW-1:0] bar_pos_q,   bar_pos_d;    // moving-bar x for this frame
    logic [HW-1:0] bar_nxt_q,   bar_nxt_d;    // moving-bar x for the next frame
    logic [FW-1:0] frame_cnt_q, frame_cnt_d;

    logic          hsync_q,     hsync_d;
    logic          vsync_q,     vsync_d;
    logic          de_q,        de_d;
    logic [5:0]    red_q,       red_d;
    logic [5:0]    green_q,     green_d;
    logic [5:0]    blue_q,      blue_d;
    logic          fs_q,        fs_d;

    // ------------------------------------------------------------------
    // Shared decode of the current raster position
    // ------------------------------------------------------------------
    logic          sof;          // counters at (0,0) while running
    pattern_e      pat_cur;      // pattern applying to the pixel being decoded
    logic [HW-1:0] pos_cur;      // moving-bar x applying to this pixel
    logic          h_act;
    logic          v_act;
    logic          hs_on;
    logic          vs_on;
    logic          in_bar;
    logic [XW-1:0] bar_step_sum;

    assign sof     = enable && (h_cnt_q == '0) && (v_cnt_q == '0);
    // The first pixel of a frame already uses the freshly selected pattern
    assign pat_cur = sof ? pattern_e'(pattern_sel) : pat_q;
    assign pos_cur = sof ? bar_nxt_q : bar_pos_q;

    assign h_act   = (h_cnt_q < H_ACT_END);
    assign v_act   = (v_cnt_q < V_ACT_END);
    assign hs_on   = (h_cnt_q >= H_SYNC_BEG) && (h_cnt_q < H_SYNC_END);
    assign vs_on   = (v_cnt_q >= V_SYNC_BEG) && (v_cnt_q < V_SYNC_END);

    // Bar may extend past H_ACTIVE; DataEnable clips it at the right edge
    assign in_bar  = ({1'b0, h_cnt_q} >= {1'b0, pos_cur}) &&
                     ({1'b0, h_cnt_q} <  ({1'b0, pos_cur} + MB_LEN));

    assign bar_step_sum = {1'b0, bar_nxt_q} + MB_STEP;

    // Raster counters and the colour-bar tracker that follows h_cnt
    always_comb begin
        // NOTE: every variable gets a default first, so no path through this
        // block leaves a value unassigned and no latch is inferred.
        h_cnt_d   = h_cnt_q;
        v_cnt_d   = v_cnt_q;
        bar_px_d  = bar_px_q;
        bar_idx_d = bar_idx_q;

        if (!enable) begin
            h_cnt_d = '0;
            v_cnt_d = '0;
        end else if (h_cnt_q == H_LAST) begin
            h_cnt_d = '0;
            v_cnt_d = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + 1'b1;
        end else begin
            h_cnt_d = h_cnt_q + 1'b1;
        end

        // Bar index is kept in step with h_cnt so no divider is needed
        if (h_cnt_d == '0) begin
            bar_px_d  = '0;
            bar_idx_d = '0;
        end else if (bar_px_q == BAR_PX_LAST) begin
            bar_px_d  = '0;
            bar_idx_d = bar_idx_q + 1'b1;
        end else begin
            bar_px_d  = bar_px_q + 1'b1;
        end
    end

    // Frame-boundary state: pattern latch, moving-bar position, frame count
    always_comb begin
        pat_d       = pat_cur;
        bar_pos_d   = pos_cur;
        bar_nxt_d   = bar_nxt_q;
        frame_cnt_d = frame_cnt_q;

        if (sof) begin
            bar_nxt_d   = (bar_step_sum >= MB_LIMIT) ? '0 : bar_step_sum[HW-1:0];
            frame_cnt_d = frame_cnt_q + 1'b1;
        end
    end

    // Sync, DataEnable and pixel colour for the current raster position
    always_comb begin
        hsync_d = ~HS_POL;
        vsync_d = ~VS_POL;
        de_d    = 1'b0;
        fs_d    = 1'b0;
        red_d   = '0;
        green_d = '0;
        blue_d  = '0;

        if (enable) begin
            hsync_d = hs_on ? HS_POL : ~HS_POL;
            vsync_d = vs_on ? VS_POL : ~VS_POL;
            de_d    = h_act && v_act;
            fs_d    = sof;

            if (de_d) begin
                case (pat_cur)
                    // white, yellow, cyan, green, magenta, red, blue, black:
                    // R drops on idx[1], G on idx[2], B on idx[0]
                    PAT_BARS: begin
                        red_d   = {6{~bar_idx_q[1]}};
                        green_d = {6{~bar_idx_q[2]}};
                        blue_d  = {6{~bar_idx_q[0]}};
                    end
                    PAT_RAMP: begin
                        red_d   = h_cnt_q[5:0];
                        green_d = h_cnt_q[5:0];
                        blue_d  = h_cnt_q[5:0];
                    end
                    PAT_CHECKER: begin
                        red_d   = {6{~(h_cnt_q[5] ^ v_cnt_q[5])}};
                        green_d = {6{~(h_cnt_q[5] ^ v_cnt_q[5])}};
                        blue_d  = {6{~(h_cnt_q[5] ^ v_cnt_q[5])}};
                    end
                    PAT_MOVING: begin
                        red_d   = {6{in_bar}};
                        green_d = {6{in_bar}};
                        blue_d  = {6{in_bar}};
                    end
                    default: begin
                        red_d   = '0;
                        green_d = '0;
                        blue_d  = '0;
                    end
                endcase
            end
        end
    end

    // Raster and frame state registers with synchronous reset
    always_ff @(posedge pixel_clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples the pre-edge values, independent of statement order.
        if (rst) begin
            h_cnt_q     <= '0;
            v_cnt_q     <= '0;
            bar_px_q    <= '0;
            bar_idx_q   <= '0;
            pat_q       <= PAT_BARS;
            bar_pos_q   <= '0;
            bar_nxt_q   <= '0;
            frame_cnt_q <= '0;
        end else begin
            h_cnt_q     <= h_cnt_d;
            v_cnt_q     <= v_cnt_d;
            bar_px_q    <= bar_px_d;
            bar_idx_q   <= bar_idx_d;
            pat_q       <= pat_d;
            bar_pos_q   <= bar_pos_d;
            bar_nxt_q   <= bar_nxt_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

    // Output registers: one cycle behind the counters, idle levels on reset
    always_ff @(posedge pixel_clk) begin
        if (rst) begin
            hsync_q <= ~HS_POL;
            vsync_q <= ~VS_POL;
            de_q    <= 1'b0;
            red_q   <= '0;
            green_q <= '0;
            blue_q  <= '0;
            fs_q    <= 1'b0;
        end else begin
            hsync_q <= hsync_d;
            vsync_q <= vsync_d;
            de_q    <= de_d;
            red_q   <= red_d;
            green_q <= green_d;
            blue_q  <= blue_d;
            fs_q    <= fs_d;
        end
    end

    assign HSync       = hsync_q;
    assign VSync       = vsync_q;
    assign DataEnable  = de_q;
    assign Red         = red_q;
    assign Green       = green_q;
    assign Blue        = blue_q;
    assign frame_start = fs_q;

endmodule
